// File: rtl/mips_pkg.sv
// Shared types and constants for the PipelineCPU instruction-fetch front end.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] WORD_STEP        = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetch that completed while ID was stalled.
module if_skid_buf
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] pc4_i,
  input  logic [DATA_W-1:0] instr_i,
  output logic              full_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc4_o,
  output logic [DATA_W-1:0] instr_o
);

  logic              full_d,  full_q;
  logic [ADDR_W-1:0] pc_d,    pc_q;
  logic [ADDR_W-1:0] pc4_d,   pc4_q;
  logic [DATA_W-1:0] instr_d, instr_q;

  // Clear takes priority so a flush always empties the entry.
  always_comb begin
    full_d  = full_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    if (clear_i) begin
      full_d  = 1'b0;
      pc_d    = '0;
      pc4_d   = '0;
      instr_d = DATA_W'(NOP_INSTR);
    end else if (load_i) begin
      full_d  = 1'b1;
      pc_d    = pc_i;
      pc4_d   = pc4_i;
      instr_d = instr_i;
    end else begin
      full_d  = full_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      pc4_q   <= '0;
      instr_q <= DATA_W'(NOP_INSTR);
    end else begin
      full_q  <= full_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
    end
  end

  assign full_o  = full_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC register, fetch FSM, imem handshake and IF/ID register.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ready_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              if_id_valid_o,
  output logic [ADDR_W-1:0] if_id_pc_o,
  output logic [ADDR_W-1:0] if_id_pc4_o,
  output logic [DATA_W-1:0] if_id_instr_o
);

  fetch_state_e      state_d, state_q;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic              req_d, req_q;
  logic              valid_d, valid_q;
  logic [ADDR_W-1:0] id_pc_d, id_pc_q;
  logic [ADDR_W-1:0] id_pc4_d, id_pc4_q;
  logic [DATA_W-1:0] id_instr_d, id_instr_q;

  logic              fetch_done_s;
  logic [ADDR_W-1:0] pc_plus4_s;
  logic              skid_load_s, skid_clear_s, skid_full_s;
  logic [ADDR_W-1:0] skid_pc_s, skid_pc4_s;
  logic [DATA_W-1:0] skid_instr_s;

  assign fetch_done_s = req_q & imem_ready_i;
  assign pc_plus4_s   = pc_q + ADDR_W'(WORD_STEP);

  if_skid_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load_s),
    .clear_i (skid_clear_s),
    .pc_i    (pc_q),
    .pc4_i   (pc_plus4_s),
    .instr_i (imem_rdata_i),
    .full_o  (skid_full_s),
    .pc_o    (skid_pc_s),
    .pc4_o   (skid_pc4_s),
    .instr_o (skid_instr_s)
  );

  // Next-state logic; a redirect overrides the FSM and discards any fetch finishing now.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    id_pc_d      = id_pc_q;
    id_pc4_d     = id_pc4_q;
    id_instr_d   = id_instr_q;
    skid_load_s  = 1'b0;
    skid_clear_s = 1'b0;
    if (redirect_i) begin
      pc_d         = {redirect_addr_i[ADDR_W-1:2], 2'b00};
      valid_d      = 1'b0;
      id_instr_d   = DATA_W'(NOP_INSTR);
      skid_clear_s = 1'b1;
      state_d      = FETCH;
    end else begin
      case (state_q)
        BOOT: begin
          state_d = FETCH;
        end
        FETCH: begin
          if (fetch_done_s) begin
            pc_d = pc_plus4_s;
            if (!stall_i) begin
              valid_d    = 1'b1;
              id_pc_d    = pc_q;
              id_pc4_d   = pc_plus4_s;
              id_instr_d = imem_rdata_i;
            end else begin
              skid_load_s = 1'b1;
              state_d     = HOLD;
            end
          end else if (!stall_i) begin
            valid_d    = 1'b0;
            id_instr_d = DATA_W'(NOP_INSTR);
          end else begin
            state_d = FETCH;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            valid_d      = skid_full_s;
            id_pc_d      = skid_pc_s;
            id_pc4_d     = skid_pc4_s;
            id_instr_d   = skid_instr_s;
            skid_clear_s = 1'b1;
            state_d      = FETCH;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
    req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
      id_instr_q <= DATA_W'(NOP_INSTR);
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_instr_q <= id_instr_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign if_id_valid_o = valid_q;
  assign if_id_pc_o    = id_pc_q;
  assign if_id_pc4_o   = id_pc4_q;
  assign if_id_instr_o = id_instr_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a wait-state-programmable memory returning addr>>2.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;
  logic [31:0] if_id_instr_o;

  int checks = 0;
  int fails  = 0;
  int waits  = 0;
  int wcnt   = 0;

  if_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ready_i    (imem_ready_i),
    .imem_rdata_i    (imem_rdata_i),
    .if_id_valid_o   (if_id_valid_o),
    .if_id_pc_o      (if_id_pc_o),
    .if_id_pc4_o     (if_id_pc4_o),
    .if_id_instr_o   (if_id_instr_o)
  );

  always #5 clk = ~clk;

  // Memory: ready after `waits` wait cycles, data = word index of the address.
  assign imem_ready_i = imem_req_o && (wcnt >= waits);
  assign imem_rdata_i = imem_addr_o >> 2;

  always @(posedge clk) begin
    if (!imem_req_o || imem_ready_i) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin fails++; $display("FAIL reset_pc got %h want 0", imem_addr_o); end
    checks++; if (if_id_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", if_id_valid_o); end
    checks++; if (if_id_pc_o !== 32'h0 || if_id_pc4_o !== 32'h0 || if_id_instr_o !== 32'h0) begin
      fails++; $display("FAIL reset_ifid got pc=%h pc4=%h instr=%h want all 0", if_id_pc_o, if_id_pc4_o, if_id_instr_o);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    waits = 0;
    rst_n = 1'b1;
    step();
    checks++; if (imem_req_o !== 1'b1 || if_id_valid_o !== 1'b0) begin
      fails++; $display("FAIL boot_exit got req=%b valid=%b want 1 0", imem_req_o, if_id_valid_o);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      exp_pc = 32'(i) * 32'd4;
      checks++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== exp_pc || if_id_pc4_o !== exp_pc + 32'd4 ||
                    if_id_instr_o !== 32'(i)) begin
        fails++; $display("FAIL stream_%0d got v=%b pc=%h pc4=%h instr=%h want v=1 pc=%h pc4=%h instr=%h",
                          i, if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o, exp_pc, exp_pc + 32'd4, 32'(i));
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] exp_pc;
    waits = 2;
    for (int k = 0; k < 2; k++) begin
      exp_pc = 32'h10 + 32'(k) * 32'd4;
      for (int b = 0; b < 2; b++) begin
        step();
        checks++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0 || imem_req_o !== 1'b1 ||
                      imem_addr_o !== exp_pc) begin
          fails++; $display("FAIL wait_bubble_%0d_%0d got v=%b instr=%h req=%b addr=%h want v=0 instr=0 req=1 addr=%h",
                            k, b, if_id_valid_o, if_id_instr_o, imem_req_o, imem_addr_o, exp_pc);
        end
      end
      step();
      checks++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== exp_pc || if_id_instr_o !== (exp_pc >> 2)) begin
        fails++; $display("FAIL wait_done_%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                          k, if_id_valid_o, if_id_pc_o, if_id_instr_o, exp_pc, exp_pc >> 2);
      end
    end
  endtask

  task automatic test_stall();
    rst_n = 1'b0;
    waits = 0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++; if (if_id_pc_o !== 32'hC || imem_addr_o !== 32'h10) begin
      fails++; $display("FAIL stall_setup got pc=%h addr=%h want c 10", if_id_pc_o, imem_addr_o);
    end
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_req_o !== 1'b0 || if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'hC ||
                    if_id_instr_o !== 32'h3) begin
        fails++; $display("FAIL stall_hold_%0d got req=%b v=%b pc=%h instr=%h want 0 1 c 3",
                          i, imem_req_o, if_id_valid_o, if_id_pc_o, if_id_instr_o);
      end
    end
    stall_i = 1'b0;
    step();
    checks++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h10 || if_id_instr_o !== 32'h4 ||
                  imem_req_o !== 1'b1 || imem_addr_o !== 32'h14) begin
      fails++; $display("FAIL stall_release got v=%b pc=%h instr=%h req=%b addr=%h want 1 10 4 1 14",
                        if_id_valid_o, if_id_pc_o, if_id_instr_o, imem_req_o, imem_addr_o);
    end
    step();
    checks++; if (if_id_pc_o !== 32'h14 || if_id_instr_o !== 32'h5) begin
      fails++; $display("FAIL stall_next got pc=%h instr=%h want 14 5", if_id_pc_o, if_id_instr_o);
    end
  endtask

  task automatic test_redirect_fetch();
    step();
    step();
    checks++; if (imem_addr_o !== 32'h20 || imem_ready_i !== 1'b1) begin
      fails++; $display("FAIL redir_setup got addr=%h ready=%b want 20 1", imem_addr_o, imem_ready_i);
    end
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h0000_0103;
    step();
    redirect_i = 1'b0;
    checks++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0 || imem_req_o !== 1'b1 ||
                  imem_addr_o !== 32'h100) begin
      fails++; $display("FAIL redir_flush got v=%b instr=%h req=%b addr=%h want 0 0 1 100",
                        if_id_valid_o, if_id_instr_o, imem_req_o, imem_addr_o);
    end
    step();
    checks++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h100 || if_id_pc4_o !== 32'h104 ||
                  if_id_instr_o !== 32'h40) begin
      fails++; $display("FAIL redir_target got v=%b pc=%h pc4=%h instr=%h want 1 100 104 40",
                        if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o);
    end
  endtask

  task automatic test_redirect_hold();
    stall_i = 1'b1;
    step();
    step();
    checks++; if (imem_req_o !== 1'b0 || if_id_pc_o !== 32'h100) begin
      fails++; $display("FAIL hold_setup got req=%b pc=%h want 0 100", imem_req_o, if_id_pc_o);
    end
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h0000_0200;
    step();
    redirect_i = 1'b0;
    checks++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0 || imem_req_o !== 1'b1 ||
                  imem_addr_o !== 32'h200) begin
      fails++; $display("FAIL hold_redir got v=%b instr=%h req=%b addr=%h want 0 0 1 200",
                        if_id_valid_o, if_id_instr_o, imem_req_o, imem_addr_o);
    end
    step();
    stall_i = 1'b0;
    step();
    checks++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h200 || if_id_instr_o !== 32'h80) begin
      fails++; $display("FAIL hold_target got v=%b pc=%h instr=%h want 1 200 80",
                        if_id_valid_o, if_id_pc_o, if_id_instr_o);
    end
  endtask

  task automatic test_wrap_and_reset();
    redirect_i      = 1'b1;
    redirect_addr_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    checks++; if (if_id_valid_o !== 1'b0 || imem_addr_o !== 32'hFFFF_FFFC) begin
      fails++; $display("FAIL wrap_redir got v=%b addr=%h want 0 fffffffc", if_id_valid_o, imem_addr_o);
    end
    step();
    checks++; if (if_id_pc_o !== 32'hFFFF_FFFC || if_id_pc4_o !== 32'h0 || if_id_instr_o !== 32'h3FFF_FFFF ||
                  imem_addr_o !== 32'h0) begin
      fails++; $display("FAIL wrap_pc4 got pc=%h pc4=%h instr=%h addr=%h want fffffffc 0 3fffffff 0",
                        if_id_pc_o, if_id_pc4_o, if_id_instr_o, imem_addr_o);
    end
    step();
    waits = 3;
    step();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4 || imem_ready_i !== 1'b0) begin
      fails++; $display("FAIL midwait_setup got req=%b addr=%h ready=%b want 1 4 0", imem_req_o, imem_addr_o, imem_ready_i);
    end
    rst_n = 1'b0;
    step();
    checks++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0 || if_id_valid_o !== 1'b0 ||
                  if_id_pc_o !== 32'h0 || if_id_instr_o !== 32'h0) begin
      fails++; $display("FAIL midwait_reset got req=%b addr=%h v=%b pc=%h instr=%h want 0 0 0 0 0",
                        imem_req_o, imem_addr_o, if_id_valid_o, if_id_pc_o, if_id_instr_o);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait_states();
    test_stall();
    test_redirect_fetch();
    test_redirect_hold();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
